// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD block constants and drain-state encoding
//
// Shared by the block writer and the audio reader:
//   SD_BLOCK_BYTES     bytes per SD sector
//   SD_SDSC_ADDR_STEP  byte-address increment between sectors (SDSC addressing)
//   drain_state_t      sector drain FSM states
package sd_pkg;

  localparam int SD_BLOCK_BYTES = 512;
  localparam logic [31:0] SD_SDSC_ADDR_STEP = 32'd512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_ISSUE,
    ST_STREAM,
    ST_WAIT_DONE,
    ST_DONE
  } drain_state_t;

endpackage

// File: rtl/pingpong_byte_buffer.sv
// rtl/pingpong_byte_buffer.sv - two-bank byte RAM with per-bank full flags
//
// Ports:
//   clk, reset        clock, synchronous active-high reset (flags and read register)
//   clear             empties both banks (session restart)
//   wr_en/wr_bank/wr_addr/wr_data   fill-side write port
//   rd_en/rd_bank/rd_addr/rd_data   drain-side read port, one-cycle registered read
//   set_full/clr_full per-bank flag set (fill complete) and clear (drain complete)
//   full              per-bank full flags
module pingpong_byte_buffer
  import sd_pkg::*;
#(
  parameter int BLOCK_BYTES = SD_BLOCK_BYTES,
  parameter int PTR_W = $clog2(BLOCK_BYTES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [7:0]       rd_data,
  input  logic [1:0]       set_full,
  input  logic [1:0]       clr_full,
  output logic [1:0]       full
);

  logic [7:0] mem [0:2*BLOCK_BYTES-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= 8'h00;
    end else if (rd_en) begin
      rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      full <= 2'b00;
    end else begin
      full <= (full | set_full) & ~clr_full;
    end
  end

endmodule

// File: rtl/sd_block_writer.sv
// rtl/sd_block_writer.sv - streams accepted bytes into consecutive SD sectors
//
// Ports:
//   clk_25mhz, reset            SD clock, synchronous active-high reset
//   start, flush                session start / pad-and-finish pulses
//   in_data, in_valid, in_ready byte stream input (accepted on valid & ready)
//   sd_ready, sd_ready_for_next_byte, sd_wr, sd_din, sd_addr   sd_controller write port
//   busy, done, blocks_written  session status
module sd_block_writer
  import sd_pkg::*;
#(
  parameter int          BLOCK_BYTES = SD_BLOCK_BYTES,
  parameter logic [31:0] START_ADDR  = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP   = SD_SDSC_ADDR_STEP,
  parameter int          NUM_BLOCKS  = 1024
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sd_ready,
  input  logic        sd_ready_for_next_byte,
  output logic        sd_wr,
  output logic [7:0]  sd_din,
  output logic [31:0] sd_addr,
  output logic        busy,
  output logic        done,
  output logic [15:0] blocks_written
);

  localparam int PW = $clog2(BLOCK_BYTES);
  localparam logic [PW-1:0] LAST_PTR = PW'(BLOCK_BYTES - 1);
  localparam logic [15:0] NUM_BLK = 16'(NUM_BLOCKS);

  drain_state_t state, state_nx;

  logic          fill_bank, drain_bank;
  logic [PW-1:0] fill_ptr, drain_ptr, rd_addr;
  logic          padding, flush_req;
  logic [15:0]   commit_cnt;
  logic [1:0]    full, set_full, clr_full;
  logic          start_ok, can_commit, accept, fill_last, commit_now;
  logic          flush_ok, pad_needed, pad_last, pulse_ok, blk_done;

  assign busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign done       = (state == ST_DONE);
  assign sd_wr      = (state == ST_ISSUE);
  assign start_ok   = start && !busy;
  // Committed = marked full or already written; stop filling at the session size.
  assign can_commit = commit_cnt < NUM_BLK;
  assign in_ready   = busy && !padding && !flush_req && !full[fill_bank] && can_commit;
  assign accept     = in_valid && in_ready;
  assign fill_last  = (fill_ptr == LAST_PTR);
  assign pad_last   = padding && fill_last;
  assign commit_now = (accept && fill_last) || pad_last;
  assign flush_ok   = flush && busy && !flush_req && can_commit;
  // A byte accepted on the flush cycle counts first; pad only if the bank is left partial.
  assign pad_needed = flush_ok && (accept ? !fill_last : (fill_ptr != '0));
  assign pulse_ok   = (state == ST_STREAM) && sd_ready_for_next_byte;
  assign blk_done   = (state == ST_WAIT_DONE) && sd_ready;
  // Look one address ahead on a pulse so the next byte appears the following cycle.
  assign rd_addr    = pulse_ok ? drain_ptr + PW'(1) : drain_ptr;
  assign set_full   = commit_now ? (fill_bank ? 2'b10 : 2'b01) : 2'b00;
  assign clr_full   = blk_done ? (drain_bank ? 2'b10 : 2'b01) : 2'b00;

  pingpong_byte_buffer #(.BLOCK_BYTES(BLOCK_BYTES)) u_buf (
    .clk      (clk_25mhz),
    .reset    (reset),
    .clear    (start_ok),
    .wr_en    (accept || padding),
    .wr_bank  (fill_bank),
    .wr_addr  (fill_ptr),
    .wr_data  (padding ? 8'h00 : in_data),
    .rd_en    (busy),
    .rd_bank  (drain_bank),
    .rd_addr  (rd_addr),
    .rd_data  (sd_din),
    .set_full (set_full),
    .clr_full (clr_full),
    .full     (full)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (start_ok) state_nx = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (full[drain_bank] && sd_ready) state_nx = ST_ISSUE;
        else if (flush_req && !padding && (full == 2'b00)) state_nx = ST_DONE;
      end
      ST_ISSUE:  state_nx = ST_STREAM;
      ST_STREAM: if (pulse_ok && (drain_ptr == LAST_PTR)) state_nx = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (sd_ready) begin
          if ((blocks_written + 16'd1 == NUM_BLK) ||
              (flush_req && !padding && !full[~drain_bank])) state_nx = ST_DONE;
          else state_nx = ST_WAIT_RDY;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state          <= ST_IDLE;
      fill_bank      <= 1'b0;
      drain_bank     <= 1'b0;
      fill_ptr       <= '0;
      drain_ptr      <= '0;
      padding        <= 1'b0;
      flush_req      <= 1'b0;
      commit_cnt     <= 16'd0;
      blocks_written <= 16'd0;
      sd_addr        <= START_ADDR;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        fill_bank      <= 1'b0;
        drain_bank     <= 1'b0;
        fill_ptr       <= '0;
        drain_ptr      <= '0;
        padding        <= 1'b0;
        flush_req      <= 1'b0;
        commit_cnt     <= 16'd0;
        blocks_written <= 16'd0;
        sd_addr        <= START_ADDR;
      end else begin
        if (accept || padding) fill_ptr <= fill_ptr + PW'(1);
        // Banks alternate strictly, so fill and drain both just toggle on completion.
        if (commit_now) begin
          fill_bank  <= ~fill_bank;
          commit_cnt <= commit_cnt + 16'd1;
        end
        if (pad_needed)    padding <= 1'b1;
        else if (pad_last) padding <= 1'b0;
        if (flush_ok) flush_req <= 1'b1;
        if (pulse_ok) drain_ptr <= drain_ptr + PW'(1);
        if (blk_done) begin
          drain_bank     <= ~drain_bank;
          blocks_written <= blocks_written + 16'd1;
          sd_addr        <= sd_addr + ADDR_STEP;
        end
      end
    end
  end

endmodule
